instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 SHALL have parameter BOOT_ADDR, default 0, first fetch address after reset.
REQ-004 SHALL have parameter DEPTH, default 2, instruction buffer entries and maximum outstanding requests.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 pc_i  input  ADDR_WIDTH  redirect target from the program counter (jump or taken branch).
REQ-009 redirect_i  input  1  pc_i is valid; flush and restart fetching at pc_i.
REQ-010 imem_req_o  output  1  fetch request to instruction memory.
REQ-011 imem_addr_o  output  ADDR_WIDTH  fetch address; word aligned.
REQ-012 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-013 imem_rvalid_i  input  1  response data valid; responses return in order, at least 1 cycle after grant.
REQ-014 imem_rdata_i  input  INSTR_WIDTH  response instruction word.
REQ-015 instr_valid_o  output  1  instr_o/instr_addr_o hold a valid instruction for the decoder.
REQ-016 instr_o  output  INSTR_WIDTH  buffer-head instruction.
REQ-017 instr_addr_o  output  ADDR_WIDTH  address of instr_o.
REQ-018 instr_ready_i  input  1  decoder consumes the head when instr_valid_o is high.

Function
REQ-019 SHALL keep fetch address faddr; imem_addr_o = faddr; faddr += 4 on each cycle with imem_req_o && imem_gnt_i, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL track outstanding (granted, response not yet received) and occupancy (buffer entries); imem_req_o = (outstanding + occupancy < DEPTH) in state FETCH.
REQ-021 SHALL hold imem_addr_o stable while imem_req_o && !imem_gnt_i, except on redirect_i.
REQ-022 SHALL implement states RESET_WAIT (after reset, req low, 1 cycle) -> FETCH; FETCH -> STALL when credits exhausted; STALL -> FETCH when a credit frees; any state -> FETCH on redirect_i.
REQ-023 SHALL push imem_rdata_i with its address into an in-order DEPTH-entry FIFO on imem_rvalid_i when drop count is zero; buffered addresses tracked internally.
REQ-024 SHALL assert instr_valid_o whenever FIFO non-empty; head pops on instr_valid_o && instr_ready_i; zero-cycle head-to-output latency; minimum grant-to-instr_valid_o latency 1 cycle after rvalid edge.
REQ-025 SHALL allow simultaneous push and pop on a full FIFO; never overflow, since credits bound entries.
REQ-026 On redirect_i: clear FIFO; set drop count = outstanding after this edge (including a grant in the same cycle, excluding an rvalid in the same cycle); faddr <= pc_i with low 2 bits forced to 0; pop in same cycle ignored.
REQ-027 SHALL decrement drop count on each imem_rvalid_i while nonzero and discard that data; new-stream requests may issue while drops pend, subject to REQ-020.
REQ-028 Redirect while a request is pending ungranted: address switches to pc_i next cycle; no grant counted for old address.
REQ-029 instr_valid_o SHALL be low the cycle after any redirect_i.

Reset
REQ-030 While rst_n low: imem_req_o=0, imem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_addr_o=0, FIFO empty, outstanding=0, drop=0, state RESET_WAIT.
REQ-031 Reset asserted mid-transaction SHALL abandon all outstanding responses; responses arriving after release with zero outstanding SHALL be ignored.
REQ-032 First imem_req_o SHALL rise 1 cycle after rst_n deasserts.

Verification
REQ-033 Reset release, gnt always 1, rvalid 1 cycle later, ready=1 -> addrs 0x0,0x4,0x8 fetched; instr_addr_o 0x0,0x4,0x8 on consecutive cycles.
REQ-034 ready=0, memory responsive -> exactly 2 grants, FIFO full, imem_req_o low; ready=1 for one cycle -> one new request issues.
REQ-035 Two outstanding (0x8,0xC), redirect_i with pc_i=0x100 -> both responses dropped; next instr_addr_o=0x100.
REQ-036 redirect_i same cycle as grant of 0x10, pc_i=0x42 -> 0x10 response dropped; imem_addr_o=0x40.
REQ-037 faddr=0xFFFFFFFC granted -> next imem_addr_o=0x00000000.
REQ-038 rst_n low with 2 outstanding, release, late rvalid -> instr_valid_o stays 0; fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue to instruction memory,
// in-order response buffering, and redirect flush with stale-response dropping.
module instr_fetch #(
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0,
  parameter int unsigned           DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic                   redirect_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_ready_i
);

  localparam int unsigned           CW    = $clog2(DEPTH + 1);
  localparam int unsigned           PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]           LIMIT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]         ONE   = CW'(1);
  localparam logic [PW-1:0]         LAST  = PW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {RESET_WAIT, FETCH, STALL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_faddr, r_raddr, w_redir_addr;
  logic [CW-1:0]          r_outst, r_occ, r_drop;
  logic [CW-1:0]          w_outst_nxt, w_occ_nxt, w_drop_nxt;
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [INSTR_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_mem_addr [DEPTH];
  logic                   w_credit, w_credit_nxt;
  logic                   w_grant, w_resp, w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_redir_addr = pc_i & ALIGN;
  assign w_credit     = ({1'b0, r_outst} + {1'b0, r_occ}) < LIMIT;
  assign w_credit_nxt = ({1'b0, w_outst_nxt} + {1'b0, w_occ_nxt}) < LIMIT;

  assign imem_req_o   = (r_state == FETCH) && w_credit;
  assign imem_addr_o  = r_faddr;

  // Responses with nothing outstanding (e.g. from before a reset) are ignored.
  assign w_grant = imem_req_o & imem_gnt_i;
  assign w_resp  = imem_rvalid_i & (r_outst != '0);
  assign w_push  = w_resp & (r_drop == '0) & ~redirect_i;
  assign w_pop   = instr_valid_o & instr_ready_i & ~redirect_i;

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_grant) w_outst_nxt = w_outst_nxt + ONE;
    if (w_resp)  w_outst_nxt = w_outst_nxt - ONE;

    w_occ_nxt = r_occ;
    if (w_push) w_occ_nxt = w_occ_nxt + ONE;
    if (w_pop)  w_occ_nxt = w_occ_nxt - ONE;
    if (redirect_i) w_occ_nxt = '0;

    // Everything still in flight after a redirect belongs to the old stream.
    w_drop_nxt = r_drop;
    if (redirect_i)                  w_drop_nxt = w_outst_nxt;
    else if (w_resp && r_drop != '0) w_drop_nxt = r_drop - ONE;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RESET_WAIT: w_state_nxt = FETCH;
      FETCH:      if (!w_credit_nxt) w_state_nxt = STALL;
      STALL:      if (w_credit_nxt)  w_state_nxt = FETCH;
      default:    w_state_nxt = RESET_WAIT;
    endcase
    if (redirect_i) w_state_nxt = FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_WAIT;
      r_faddr <= BOOT_ADDR;
      r_raddr <= BOOT_ADDR;
      r_outst <= '0;
      r_occ   <= '0;
      r_drop  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      r_occ   <= w_occ_nxt;
      r_drop  <= w_drop_nxt;
      if (redirect_i) begin
        r_faddr <= w_redir_addr;
        r_raddr <= w_redir_addr;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_grant) r_faddr <= r_faddr + STEP;
        if (w_push) begin
          r_raddr <= r_raddr + STEP;
          r_wptr  <= ptr_inc(r_wptr);
        end
        if (w_pop) r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // r_raddr follows the accepted response stream, so it labels each pushed word.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= imem_rdata_i;
      r_mem_addr[r_wptr] <= r_raddr;
    end
  end

  assign instr_valid_o = (r_occ != '0);
  assign instr_o       = instr_valid_o ? r_mem_data[r_rptr] : '0;
  assign instr_addr_o  = instr_valid_o ? r_mem_addr[r_rptr] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model with a per-cycle compare,
// randomized memory/decoder/redirect stimulus and directed corner scenarios.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        redirect_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        instr_ready_i = 1'b0;

  instr_fetch #(
    .INSTR_WIDTH(32),
    .ADDR_WIDTH (32),
    .BOOT_ADDR  (32'h0),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .redirect_i   (redirect_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_addr_o (instr_addr_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus knobs (percentages) and memory responder.
  int unsigned p_gnt = 0, p_ready = 0, p_redir = 0, resp_dmax = 0;
  bit          resp_en = 1'b0;
  int unsigned cyc = 0;
  int unsigned resp_q[$];

  // Observation logs.
  logic [31:0] gaddr[$];
  logic [31:0] caddr[$];
  int unsigned n_valid_cyc = 0;

  // Reference model: each in-flight request carries its own address and a stale flag.
  typedef struct {logic [31:0] addr; bit stale;} pend_t;
  typedef struct {logic [31:0] data; logic [31:0] addr;} ent_t;
  pend_t       pend[$];
  ent_t        mbuf[$];
  logic [31:0] m_faddr = '0;
  bit          m_wait = 1'b1;
  bit          m_req;
  pend_t       pe;
  ent_t        me;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_wait  = 1'b1;
        m_faddr = 32'h0;
        pend.delete();
        mbuf.delete();
      end
      m_req = !m_wait && (pend.size() + mbuf.size() < DEPTH);
      chk("imem_req", 64'(imem_req_o), 64'(m_req));
      chk("imem_addr", 64'(imem_addr_o), 64'(m_faddr));
      chk("instr_valid", 64'(instr_valid_o), 64'(mbuf.size() > 0));
      if (!rst_n) begin
        chk("rst_instr", 64'(instr_o), 64'(0));
        chk("rst_instr_addr", 64'(instr_addr_o), 64'(0));
      end else if (mbuf.size() > 0 && instr_valid_o) begin
        chk("instr", 64'(instr_o), 64'(mbuf[0].data));
        chk("instr_addr", 64'(instr_addr_o), 64'(mbuf[0].addr));
      end
      if (rst_n) begin
        if (instr_valid_o) n_valid_cyc++;
        if (imem_req_o && imem_gnt_i) begin
          int unsigned ret;
          gaddr.push_back(imem_addr_o);
          ret = cyc + 1 + $urandom_range(resp_dmax);
          if (resp_q.size() > 0 && ret <= resp_q[$]) ret = resp_q[$] + 1;
          resp_q.push_back(ret);
        end
        if (instr_valid_o && instr_ready_i && !redirect_i) caddr.push_back(instr_addr_o);

        if (mbuf.size() > 0 && instr_ready_i && !redirect_i) void'(mbuf.pop_front());
        if (imem_rvalid_i && pend.size() > 0) begin
          pe = pend.pop_front();
          if (!pe.stale) begin
            me.data = imem_rdata_i;
            me.addr = pe.addr;
            mbuf.push_back(me);
          end
        end
        if (m_req && imem_gnt_i) begin
          pe.addr  = m_faddr;
          pe.stale = 1'b0;
          pend.push_back(pe);
          m_faddr = m_faddr + 32'd4;
        end
        if (redirect_i) begin
          foreach (pend[i]) pend[i].stale = 1'b1;
          mbuf.delete();
          m_faddr = {pc_i[31:2], 2'b00};
        end
        m_wait = 1'b0;
      end
    end
  end

  task automatic tick(input bit force_redir, input logic [31:0] force_pc);
    @(posedge clk);
    #1;
    cyc++;
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    instr_ready_i = ($urandom_range(99) < p_ready);
    if (force_redir) begin
      redirect_i = 1'b1;
      pc_i       = force_pc;
    end else begin
      redirect_i = ($urandom_range(99) < p_redir);
      pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
    end
    imem_rdata_i = $urandom();
    if (resp_en && resp_q.size() > 0 && resp_q[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      void'(resp_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, '0);
  endtask

  task automatic do_reset(input bit flush);
    p_gnt = 0; p_ready = 0; p_redir = 0; resp_en = 1'b0;
    tick(1'b0, '0);
    rst_n = 1'b0;
    if (flush) resp_q.delete();
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    gaddr.delete();
    caddr.delete();
  endtask

  // Two requests issued with responses held, then released and consumed.
  task automatic pair();
    p_gnt = 100; resp_en = 1'b0; run(3);
    p_gnt = 0;   resp_en = 1'b1; run(5);
  endtask

  initial begin
    // Reset values
    run(2);
    chk("rst_req_lit", 64'(imem_req_o), 64'(0));
    chk("rst_addr_lit", 64'(imem_addr_o), 64'(0));
    chk("rst_valid_lit", 64'(instr_valid_o), 64'(0));

    // Streaming from reset: first request one cycle after release
    do_reset(1'b1);
    clear_logs();
    chk("first_req_low", 64'(imem_req_o), 64'(0));
    p_gnt = 100; p_ready = 100; resp_en = 1'b1; resp_dmax = 0;
    run(1);
    chk("first_req_high", 64'(imem_req_o), 64'(1));
    run(11);
    chk("stream_g0", 64'(gaddr[0]), 64'h0);
    chk("stream_g1", 64'(gaddr[1]), 64'h4);
    chk("stream_g2", 64'(gaddr[2]), 64'h8);
    chk("stream_c0", 64'(caddr[0]), 64'h0);
    chk("stream_c1", 64'(caddr[1]), 64'h4);
    chk("stream_c2", 64'(caddr[2]), 64'h8);

    // Decoder stalled: credits stop issue at DEPTH
    do_reset(1'b1);
    clear_logs();
    p_gnt = 100; p_ready = 0; resp_en = 1'b1; resp_dmax = 0;
    run(10);
    chk("full_grants", 64'(gaddr.size()), 64'(2));
    chk("full_valid", 64'(instr_valid_o), 64'(1));
    chk("full_req", 64'(imem_req_o), 64'(0));
    chk("full_head", 64'(instr_addr_o), 64'h0);
    p_ready = 100; run(1);
    p_ready = 0;   run(5);
    chk("one_more_grant", 64'(gaddr.size()), 64'(3));
    chk("head_after_pop", 64'(instr_addr_o), 64'h4);

    // Redirect with two requests outstanding (0x8, 0xC)
    do_reset(1'b1);
    clear_logs();
    p_ready = 100; resp_dmax = 0;
    pair();
    p_gnt = 100; resp_en = 1'b0; run(3);
    chk("two_out_g3", 64'(gaddr[3]), 64'hC);
    p_gnt = 0;
    tick(1'b1, 32'h100);
    run(1);
    chk("redir_valid_low", 64'(instr_valid_o), 64'(0));
    chk("redir_addr", 64'(imem_addr_o), 64'h100);
    p_gnt = 100; resp_en = 1'b1; run(10);
    chk("redir_next_instr", 64'(caddr[2]), 64'h100);

    // Redirect in the same cycle as the grant of 0x10, unaligned target
    do_reset(1'b1);
    clear_logs();
    p_ready = 100; resp_dmax = 0;
    pair();
    pair();
    p_gnt = 100; resp_en = 1'b0;
    tick(1'b1, 32'h42);
    p_gnt = 0; run(1);
    chk("same_cyc_grant", 64'(gaddr[4]), 64'h10);
    chk("same_cyc_addr", 64'(imem_addr_o), 64'h40);
    chk("same_cyc_valid", 64'(instr_valid_o), 64'(0));
    p_gnt = 100; resp_en = 1'b1; run(10);
    chk("same_cyc_next", 64'(caddr[4]), 64'h40);

    // Address wrap
    do_reset(1'b1);
    clear_logs();
    p_ready = 100; resp_dmax = 0;
    tick(1'b1, 32'hFFFF_FFFE);
    run(1);
    chk("wrap_start", 64'(imem_addr_o), 64'hFFFF_FFFC);
    p_gnt = 100; run(1);
    p_gnt = 0;   run(1);
    chk("wrap_addr", 64'(imem_addr_o), 64'h0);
    p_gnt = 100; resp_en = 1'b1; run(8);
    chk("wrap_c0", 64'(caddr[0]), 64'hFFFF_FFFC);
    chk("wrap_c1", 64'(caddr[1]), 64'h0);

    // Reset with two outstanding; late responses after release are ignored
    do_reset(1'b1);
    p_ready = 100; p_gnt = 100; resp_en = 1'b0; run(3);
    do_reset(1'b0);
    clear_logs();
    n_valid_cyc = 0;
    p_ready = 100; p_gnt = 0; resp_en = 1'b1; run(6);
    chk("late_valid_cycles", 64'(n_valid_cyc), 64'(0));
    chk("late_boot_addr", 64'(imem_addr_o), 64'h0);
    p_gnt = 100; run(2);
    chk("late_restart", 64'(gaddr[0]), 64'h0);

    // Randomized traffic
    do_reset(1'b1);
    clear_logs();
    p_gnt = 70; p_ready = 70; p_redir = 4; resp_en = 1'b1; resp_dmax = 3;
    run(3000);
    p_gnt = 50; p_ready = 20; p_redir = 10; resp_dmax = 1;
    run(1500);
    p_gnt = 100; p_ready = 100; p_redir = 2; resp_dmax = 0;
    run(1000);
    chk("random_progress", 64'(caddr.size() > 0), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
